// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 16-bit single-bus CPU control path.
// States, opcodes, ALU selects, flag indices and the strobe bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH_ADDR  = 3'd0,
    S_FETCH_INSTR = 3'd1,
    S_EXEC1       = 3'd2,
    S_EXEC2       = 3'd3,
    S_HALTED      = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_ALU = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_in;
    logic a_load;
    logic a_out;
    logic b_load;
    logic out_load;
    logic sum_out;
    logic ir_out;
    logic ir_load;
    logic flags_load;
  } strobe_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational micro-op decoder: state + IR fields + flags -> strobes.
// Also reports the last step of an instruction and halt requests.
module control_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic [2:0] i_alu_sel,
  input  logic [1:0] i_flags_q,
  output strobe_t    o_strobe,
  output logic [2:0] o_operation,
  output logic       o_last,
  output logic       o_halt
);

  // Decode the strobe set for the current step of the current opcode
  always_comb begin
    o_strobe    = '0;
    o_last      = 1'b0;
    o_halt      = 1'b0;
    o_operation = (i_opcode == OP_ALU) ? i_alu_sel : ALU_ADD;
    unique case (i_state)
      S_FETCH_ADDR: begin
        o_strobe.pc_out   = 1'b1;
        o_strobe.mar_load = 1'b1;
      end
      S_FETCH_INSTR: begin
        o_strobe.ram_out = 1'b1;
        o_strobe.ir_load = 1'b1;
        o_strobe.pc_inc  = 1'b1;
      end
      S_EXEC1: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA, OP_LDB, OP_STA: begin
            o_strobe.ir_out   = 1'b1;
            o_strobe.mar_load = 1'b1;
            o_last            = 1'b0;
          end
          OP_LDI: begin
            o_strobe.ir_out = 1'b1;
            o_strobe.a_load = 1'b1;
          end
          OP_ALU: begin
            o_strobe.sum_out    = 1'b1;
            o_strobe.a_load     = 1'b1;
            o_strobe.flags_load = 1'b1;
          end
          OP_JMP: begin
            o_strobe.ir_out  = 1'b1;
            o_strobe.pc_load = 1'b1;
          end
          OP_JZ: begin
            o_strobe.ir_out  = i_flags_q[FLAG_Z];
            o_strobe.pc_load = i_flags_q[FLAG_Z];
          end
          OP_JC: begin
            o_strobe.ir_out  = i_flags_q[FLAG_C];
            o_strobe.pc_load = i_flags_q[FLAG_C];
          end
          OP_OUT: begin
            o_strobe.a_out    = 1'b1;
            o_strobe.out_load = 1'b1;
          end
          OP_HLT: o_halt = 1'b1;
          OP_NOP: o_halt = 1'b0;
          default: o_halt = HALT_ON_ILLEGAL;
        endcase
      end
      S_EXEC2: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA: begin
            o_strobe.ram_out = 1'b1;
            o_strobe.a_load  = 1'b1;
          end
          OP_LDB: begin
            o_strobe.ram_out = 1'b1;
            o_strobe.b_load  = 1'b1;
          end
          OP_STA: begin
            o_strobe.a_out  = 1'b1;
            o_strobe.ram_in = 1'b1;
          end
          default: o_last = 1'b1;
        endcase
      end
      default: o_last = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: state, IR, status flags and bus drive.
// Strobes come from control_decoder, gated by Enable and Rst.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  inout  wire  [15:0] Bus,
  input  logic [1:0]  Flags,
  output logic        PcOut,
  output logic        PcInc,
  output logic        PcLoad,
  output logic        MarLoad,
  output logic        RamOut,
  output logic        RamIn,
  output logic        ALoad,
  output logic        AOut,
  output logic        BLoad,
  output logic        OutLoad,
  output logic        SumOut,
  output logic [2:0]  Operation,
  output logic [1:0]  FlagsQ,
  output logic        Halted,
  output logic [2:0]  State
);

  localparam int PAD = 16 - ADDR_WIDTH;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  logic [1:0]  r_flags_q;
  strobe_t     w_dec;
  strobe_t     w_strb;
  logic [2:0]  w_op;
  logic        w_last;
  logic        w_halt;
  logic        w_run;
  logic [15:0] w_operand;

  control_decoder #(
    .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
  ) u_dec (
    .i_state    (r_state),
    .i_opcode   (r_ir[15:12]),
    .i_alu_sel  (r_ir[2:0]),
    .i_flags_q  (r_flags_q),
    .o_strobe   (w_dec),
    .o_operation(w_op),
    .o_last     (w_last),
    .o_halt     (w_halt)
  );

  assign w_run     = Enable && !Rst;
  assign w_strb    = w_run ? w_dec : '0;
  assign w_operand = {{PAD{1'b0}}, r_ir[ADDR_WIDTH-1:0]};
  assign Bus       = w_strb.ir_out ? w_operand : {16{1'bz}};

  // Next-state selection; a stalled or halted sequencer holds its state
  always_comb begin
    w_state_nxt = r_state;
    if (Rst) begin
      w_state_nxt = S_FETCH_ADDR;
    end else if (Enable) begin
      unique case (r_state)
        S_FETCH_ADDR:  w_state_nxt = S_FETCH_INSTR;
        S_FETCH_INSTR: w_state_nxt = S_EXEC1;
        S_EXEC1: begin
          if (w_halt)      w_state_nxt = S_HALTED;
          else if (w_last) w_state_nxt = S_FETCH_ADDR;
          else             w_state_nxt = S_EXEC2;
        end
        S_EXEC2:  w_state_nxt = S_FETCH_ADDR;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // State, instruction register and status flag registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_FETCH_ADDR;
      r_ir      <= '0;
      r_flags_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_strb.ir_load)    r_ir      <= Bus;
      if (w_strb.flags_load) r_flags_q <= Flags;
    end
  end

  assign PcOut     = w_strb.pc_out;
  assign PcInc     = w_strb.pc_inc;
  assign PcLoad    = w_strb.pc_load;
  assign MarLoad   = w_strb.mar_load;
  assign RamOut    = w_strb.ram_out;
  assign RamIn     = w_strb.ram_in;
  assign ALoad     = w_strb.a_load;
  assign AOut      = w_strb.a_out;
  assign BLoad     = w_strb.b_load;
  assign OutLoad   = w_strb.out_load;
  assign SumOut    = w_strb.sum_out;
  assign Operation = Rst ? 3'b000 : w_op;
  assign FlagsQ    = r_flags_q;
  assign Halted    = !Rst && (r_state == S_HALTED);
  assign State     = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer, both illegal-opcode policies.
// Instruction-level reference model feeds per-cycle expectations.
module tb_control_sequencer;

  localparam logic [10:0] PCO  = 11'h400;
  localparam logic [10:0] PCI  = 11'h200;
  localparam logic [10:0] PCL  = 11'h100;
  localparam logic [10:0] MAR  = 11'h080;
  localparam logic [10:0] RAMO = 11'h040;
  localparam logic [10:0] RAMI = 11'h020;
  localparam logic [10:0] AL   = 11'h010;
  localparam logic [10:0] AO   = 11'h008;
  localparam logic [10:0] BL   = 11'h004;
  localparam logic [10:0] OUTL = 11'h002;
  localparam logic [10:0] SUM  = 11'h001;

  typedef struct packed {
    logic [2:0]  st;
    logic [10:0] strb;
    logic [2:0]  op;
    logic [1:0]  fq;
    logic        halted;
    logic [15:0] bus;
  } exp_t;

  typedef struct packed {
    logic [1:0]  n;
    logic [10:0] s1;
    logic [10:0] s2;
    logic        io1;
    logic        io2;
    logic        halt;
    logic        latch;
  } plan_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic [1:0]  flags;
  logic [15:0] drv_word;
  logic [1:0]  drv_en;
  wire  [15:0] bus0;
  wire  [15:0] bus1;

  assign bus0 = drv_en[0] ? drv_word : 16'hzzzz;
  assign bus1 = drv_en[1] ? drv_word : 16'hzzzz;

  logic [1:0] pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in;
  logic [1:0] a_load, a_out, b_load, out_load, sum_out, halted;
  logic [2:0] op_o  [2];
  logic [1:0] fq_o  [2];
  logic [2:0] st_o  [2];

  control_sequencer #(.ADDR_WIDTH(12), .HALT_ON_ILLEGAL(1'b0)) dut0 (
    .Clk(clk), .Rst(rst), .Enable(en), .Bus(bus0), .Flags(flags),
    .PcOut(pc_out[0]), .PcInc(pc_inc[0]), .PcLoad(pc_load[0]),
    .MarLoad(mar_load[0]), .RamOut(ram_out[0]), .RamIn(ram_in[0]),
    .ALoad(a_load[0]), .AOut(a_out[0]), .BLoad(b_load[0]),
    .OutLoad(out_load[0]), .SumOut(sum_out[0]), .Operation(op_o[0]),
    .FlagsQ(fq_o[0]), .Halted(halted[0]), .State(st_o[0])
  );

  control_sequencer #(.ADDR_WIDTH(12), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .Clk(clk), .Rst(rst), .Enable(en), .Bus(bus1), .Flags(flags),
    .PcOut(pc_out[1]), .PcInc(pc_inc[1]), .PcLoad(pc_load[1]),
    .MarLoad(mar_load[1]), .RamOut(ram_out[1]), .RamIn(ram_in[1]),
    .ALoad(a_load[1]), .AOut(a_out[1]), .BLoad(b_load[1]),
    .OutLoad(out_load[1]), .SumOut(sum_out[1]), .Operation(op_o[1]),
    .FlagsQ(fq_o[1]), .Halted(halted[1]), .State(st_o[1])
  );

  // reference model: position within the instruction, IR and status flags
  int          m_step [2];
  bit          m_halt [2];
  logic [15:0] m_ir   [2];
  logic [1:0]  m_fq   [2];
  int          n_step [2];
  bit          n_halt [2];
  logic [15:0] n_ir   [2];
  logic [1:0]  n_fq   [2];

  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [15:0] prog [$];
  int          vectors = 0;
  int          miscompares = 0;

  // execute-phase micro-steps of each opcode
  function automatic plan_t plan(logic [3:0] opc, logic [1:0] fq, bit hoi);
    plan_t p;
    p = '0;
    p.n = 2'd1;
    case (opc)
      4'h1: begin p.n = 2'd2; p.s1 = MAR; p.io1 = 1; p.s2 = RAMO | AL; end
      4'h2: begin p.n = 2'd2; p.s1 = MAR; p.io1 = 1; p.s2 = RAMO | BL; end
      4'h3: begin p.n = 2'd2; p.s1 = MAR; p.io1 = 1; p.s2 = AO | RAMI; end
      4'h4: begin p.s1 = AL; p.io1 = 1; end
      4'h5: begin p.s1 = SUM | AL; p.latch = 1; end
      4'h6: begin p.s1 = PCL; p.io1 = 1; end
      4'h7: if (fq[0]) begin p.s1 = PCL; p.io1 = 1; end
      4'h8: if (fq[1]) begin p.s1 = PCL; p.io1 = 1; end
      4'h9: p.s1 = AO | OUTL;
      4'hF: p.halt = 1;
      4'h0: p.halt = 0;
      default: p.halt = hoi;
    endcase
    return p;
  endfunction

  task automatic eval(input int k, input bit r, input bit e,
                      input logic [1:0] f, input logic [15:0] w,
                      output exp_t x, output bit io);
    plan_t p;
    p = plan(m_ir[k][15:12], m_fq[k], k == 1);
    x = '0;
    io = 0;
    x.fq = m_fq[k];
    x.st = m_halt[k] ? 3'd7 : 3'(m_step[k]);
    n_step[k] = m_step[k];
    n_halt[k] = m_halt[k];
    n_ir[k]   = m_ir[k];
    n_fq[k]   = m_fq[k];
    if (r) begin
      n_step[k] = 0; n_halt[k] = 0; n_ir[k] = '0; n_fq[k] = '0;
    end else if (m_halt[k]) begin
      x.halted = 1'b1;
    end else begin
      x.op = (m_ir[k][15:12] == 4'h5) ? m_ir[k][2:0] : 3'b000;
      if (e) begin
        case (m_step[k])
          0: begin x.strb = PCO | MAR; n_step[k] = 1; end
          1: begin x.strb = RAMO | PCI; n_ir[k] = w; n_step[k] = 2; end
          2: begin
            x.strb = p.s1;
            io = p.io1;
            if (p.latch) n_fq[k] = f;
            if (p.halt) n_halt[k] = 1;
            else n_step[k] = (p.n == 2'd1) ? 0 : 3;
          end
          default: begin x.strb = p.s2; io = p.io2; n_step[k] = 0; end
        endcase
      end
    end
    x.bus = io ? {4'h0, m_ir[k][11:0]} : w;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] opc;
    int r;
    r = $urandom_range(0, 99);
    if (r < 6)       opc = 4'hF;
    else if (r < 12) opc = 4'($urandom_range(10, 14));
    else             opc = 4'($urandom_range(0, 9));
    return {opc, 12'($urandom)};
  endfunction

  // one clock of stimulus; expectations go to the scoreboard queues
  task automatic cyc(input bit r, input bit e, input logic [1:0] f);
    exp_t x0, x1;
    bit io0, io1;
    logic [15:0] w;
    if (prog.size() > 0 && !r && e && !m_halt[0] && m_step[0] == 1)
      w = prog.pop_front();
    else
      w = rand_instr();
    rst = r; en = e; flags = f; drv_word = w;
    eval(0, r, e, f, w, x0, io0);
    eval(1, r, e, f, w, x1, io1);
    drv_en = {~io1, ~io0};
    q0.push_back(x0);
    q1.push_back(x1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_step[k] = n_step[k]; m_halt[k] = n_halt[k];
      m_ir[k] = n_ir[k]; m_fq[k] = n_fq[k];
    end
    #1;
  endtask

  task automatic check(input int k, input exp_t x);
    logic [10:0] s;
    logic [15:0] b;
    bit bad;
    s = {pc_out[k], pc_inc[k], pc_load[k], mar_load[k], ram_out[k],
         ram_in[k], a_load[k], a_out[k], b_load[k], out_load[k], sum_out[k]};
    b = (k == 0) ? bus0 : bus1;
    bad = 0;
    vectors++;
    if (st_o[k] !== x.st) begin
      $display("FAIL dut%0d state got %0d want %0d t=%0t", k, st_o[k], x.st, $time);
      bad = 1;
    end
    if (s !== x.strb) begin
      $display("FAIL dut%0d strobes got %h want %h t=%0t", k, s, x.strb, $time);
      bad = 1;
    end
    if (op_o[k] !== x.op) begin
      $display("FAIL dut%0d operation got %0d want %0d t=%0t", k, op_o[k], x.op, $time);
      bad = 1;
    end
    if (fq_o[k] !== x.fq) begin
      $display("FAIL dut%0d flagsq got %b want %b t=%0t", k, fq_o[k], x.fq, $time);
      bad = 1;
    end
    if (halted[k] !== x.halted) begin
      $display("FAIL dut%0d halted got %b want %b t=%0t", k, halted[k], x.halted, $time);
      bad = 1;
    end
    if (b !== x.bus) begin
      $display("FAIL dut%0d bus got %h want %h t=%0t", k, b, x.bus, $time);
      bad = 1;
    end
    if (bad) miscompares++;
  endtask

  // monitor: compare each presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end

  initial begin
    int hcnt;
    rst = 1; en = 1; flags = 0; drv_word = 0; drv_en = 2'b11;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_step[k] = 0; m_halt[k] = 0; m_ir[k] = '0; m_fq[k] = '0;
    end
    cyc(1, 1, 0); cyc(1, 1, 0);
    prog.push_back(16'h4123); repeat (3) cyc(0, 1, 2'b00);
    prog.push_back(16'h5001); repeat (3) cyc(0, 1, 2'b01);
    prog.push_back(16'h7040); repeat (3) cyc(0, 1, 2'b10);
    prog.push_back(16'h5002); repeat (3) cyc(0, 1, 2'b00);
    prog.push_back(16'h7040); repeat (3) cyc(0, 1, 2'b11);
    prog.push_back(16'h8040); repeat (3) cyc(0, 1, 2'b11);
    prog.push_back(16'h5003); repeat (3) cyc(0, 1, 2'b10);
    prog.push_back(16'h8077); repeat (3) cyc(0, 1, 2'b00);
    prog.push_back(16'h1234); repeat (3) cyc(0, 1, 2'b00);
    cyc(1, 1, 0); cyc(1, 1, 0);
    prog.push_back(16'h3055); repeat (2) cyc(0, 1, 2'b00);
    repeat (3) cyc(0, 0, 2'b11);
    repeat (2) cyc(0, 1, 2'b00);
    prog.push_back(16'hF000); repeat (3) cyc(0, 1, 2'b00);
    for (int i = 0; i < 10; i++) cyc(0, i[0], 2'b11);
    cyc(1, 1, 0);
    prog.push_back(16'hB000); repeat (3) cyc(0, 1, 2'b00);
    repeat (2) cyc(0, 1, 2'b00);
    cyc(1, 1, 0);
    hcnt = 0;
    repeat (3000) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (m_halt[0] || m_halt[1]) begin
        hcnt++;
        if (hcnt > 8 && $urandom_range(0, 3) == 0) r = 1;
      end
      if (r) hcnt = 0;
      cyc(r, $urandom_range(0, 99) < 85, 2'($urandom));
    end
    repeat (2) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      $display("FAIL scoreboard drain got %0d/%0d want 0/0", q0.size(), q1.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute FSM for the 16-bit single-bus CPU.
- Sits directly upstream of the ALU. It owns the instruction register, sequences the load/out strobes of PC, MAR, RAM, A (ALU Reg1), B (ALU Reg2) and the output latch, and drives the ALU Operation and SumOut controls.
- Latches the ALU Flags into a status register that conditional jumps consume.

Parameters:
- ADDR_WIDTH, 12, width of the IR operand field; IR[11:0] is driven onto Bus zero-extended.
- HALT_ON_ILLEGAL, 0, if 1 an undefined opcode enters HALTED; if 0 it executes as NOP.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- Enable  input  1  when low: FSM, IR and flags hold; all strobes forced 0.
- Bus  inout  16  shared data bus; driven only while IrOut=1, else high-Z.
- Flags  input  2  ALU flags: [0] zero, [1] carry.
- PcOut, PcInc, PcLoad  output  1 each  program counter controls.
- MarLoad, RamOut, RamIn  output  1 each  memory controls.
- ALoad, AOut, BLoad, OutLoad  output  1 each  register controls.
- SumOut  output  1  ALU result onto Bus.
- Operation  output  3  ALU op select.
- FlagsQ  output  2  latched status flags: [0] Z, [1] C.
- Halted  output  1  high in HALTED.
- State  output  3  current FSM state, for debug.

Behaviour:
- Clocking and reset:
  - All registers update on posedge Clk.
  - Rst=1 (in any state, mid-instruction included) sets next state FETCH_ADDR, IR=0, FlagsQ=00.
  - While Rst=1, every strobe, Operation and Halted are forced 0 and Bus is high-Z.
- Strobes are decoded combinationally from the state register and IR; at most one Bus driver is active per cycle.
- States: FETCH_ADDR=0, FETCH_INSTR=1, EXEC1=2, EXEC2=3, HALTED=7.
  - FETCH_ADDR: PcOut, MarLoad; next FETCH_INSTR.
  - FETCH_INSTR: RamOut, IrLoad (IR<=Bus), PcInc; next EXEC1.
  - EXEC1/EXEC2: per opcode IR[15:12] as below. After the last step, next is FETCH_ADDR.
- Opcodes:
  - 0x0 NOP: EXEC1 empty. 3 cycles total.
  - 0x1 LDA: EXEC1 IrOut, MarLoad; EXEC2 RamOut, ALoad. 4 cycles.
  - 0x2 LDB: as LDA but BLoad. 4 cycles.
  - 0x3 STA: EXEC1 IrOut, MarLoad; EXEC2 AOut, RamIn. 4 cycles.
  - 0x4 LDI: EXEC1 IrOut, ALoad. 3 cycles.
  - 0x5 ALU: Operation=IR[2:0] throughout the instruction. EXEC1 SumOut, ALoad, and FlagsQ<=Flags. 3 cycles. For every other opcode Operation=000.
  - 0x6 JMP: EXEC1 IrOut, PcLoad. 3 cycles.
  - 0x7 JZ: EXEC1 IrOut, PcLoad only if FlagsQ[0]=1; else empty.
  - 0x8 JC: same test on FlagsQ[1].
  - 0x9 OUT: EXEC1 AOut, OutLoad.
  - 0xF HLT: EXEC1 goes to HALTED.
  - 0xA-0xE: NOP, or HALTED if HALT_ON_ILLEGAL=1.
- HALTED:
  - All strobes 0, Halted=1.
  - Left only by Rst; Enable has no effect.
- Flags:
  - FlagsQ changes only in EXEC1 of opcode 0x5 and on reset.
  - Jumps test the FlagsQ value held before the jump instruction.
- Enable=0: state, IR and FlagsQ hold; strobes forced 0. Resuming re-issues the held state's strobes, with no step skipped or duplicated.
- IrOut is internal; when active, Bus={4'b0, IR[11:0]}.

Decomposition:
- Package cpu_ctrl_pkg: state encoding constants, opcode constants (NOP..HLT), ALU op constants (ADD=000 ... NOT=111), flag bit indices.
- Sub-module control_decoder: purely combinational (state, IR[15:12], IR[2:0], FlagsQ) -> strobe vector.
- control_sequencer keeps the state register, IR, FlagsQ, Enable/Rst gating and the Bus tri-state.

Test Plan:
- Reset: Rst high 2 cycles during EXEC2 of LDA -> strobes 0 while Rst high; next cycle State=0 with PcOut=MarLoad=1; FlagsQ=00.
- Fetch/LDI: Bus=0x4123 in FETCH_INSTR -> IrLoad=PcInc=1; next cycle Bus=0x0123, ALoad=1; then State=0. 3 cycles total.
- ALU sub: IR=0x5001 with Flags=01 -> Operation=001 in FETCH_ADDR after fetch and EXEC1; SumOut=ALoad=1 in EXEC1; FlagsQ=01 afterwards.
- Conditional jump: JZ 0x0040 with FlagsQ[0]=1 -> PcLoad=1, Bus=0x0040. With FlagsQ[0]=0 -> no strobes, Bus high-Z. Then JC with FlagsQ[1]=0 -> not taken.
- Stall: Enable low 3 cycles in EXEC1 of STA -> strobes 0, State=2 held; on resume, EXEC1 then EXEC2 (AOut, RamIn) each exactly once.
- Halt: IR=0xF000 -> Halted=1 from the following cycle, strobes 0 for 10 cycles despite Enable toggling; Rst returns State=0. IR=0xB000 with HALT_ON_ILLEGAL=1 -> Halted=1.
